// File: rtl/hardreg_pkg.sv
// hardreg_pkg -- shared definitions for the hardreg sequence checker.
//   SEQ_LEN      : number of entries in one pattern pass
//   PAT0..PAT4   : expected register values at indices 0..4
//   state_t      : checker FSM encoding (IDLE, CHECK, DONE)
//   pattern_at() : index -> pattern lookup, 0 for unused indices 5..7
package hardreg_pkg;

    localparam int SEQ_LEN = 5;

    localparam logic [3:0] PAT0 = 4'b0000;
    localparam logic [3:0] PAT1 = 4'b0001;
    localparam logic [3:0] PAT2 = 4'b0010;
    localparam logic [3:0] PAT3 = 4'b0100;
    localparam logic [3:0] PAT4 = 4'b0101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [3:0] pattern_at(input logic [2:0] idx);
        logic [3:0] val;
        case (idx)
            3'd0:    val = PAT0;
            3'd1:    val = PAT1;
            3'd2:    val = PAT2;
            3'd3:    val = PAT3;
            3'd4:    val = PAT4;
            default: val = 4'b0000;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/hardreg_pattern_rom.sv
// hardreg_pattern_rom -- combinational lookup of the expected register value.
//   idx  : sequence index (0..7)
//   data : pattern zero-extended to WIDTH; indices 5..7 return 0
module hardreg_pattern_rom
    import hardreg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       idx,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] rom_table [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rom
            assign rom_table[gi] = WIDTH'(pattern_at(3'(gi)));
        end
    endgenerate

    assign data = rom_table[idx];

endmodule

// File: rtl/hardreg_seq_checker.sv
// hardreg_seq_checker -- checks an observed register output against the fixed
// pattern 0,1,2,4,5 repeated PASSES times.
//   clk, clr        : clock and synchronous active-high reset
//   start           : begins / restarts a run (beats a coincident sample_en)
//   sample_en, q_in : one compare of q_in against exp_data per strobe in CHECK
//   busy, done      : state flags (CHECK / DONE)
//   pass_pulse      : one cycle, alongside the result for index 4
//   match, mismatch : registered compare result, one cycle after the strobe
//   exp_data        : value expected at the next sample, 0 outside CHECK
//   match_cnt, err_cnt : saturating per-run compare counters
//   first_err_idx, first_err_data : first mismatch capture of the run
// Build option: define HARDREG_FIRST_ERR_EN to enable first-mismatch capture;
// otherwise the capture outputs are tied to 0.
module hardreg_seq_checker
    import hardreg_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int PASSES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] q_in,
    output logic             busy,
    output logic             done,
    output logic             pass_pulse,
    output logic             match,
    output logic             mismatch,
    output logic [WIDTH-1:0] exp_data,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [2:0]       first_err_idx,
    output logic [WIDTH-1:0] first_err_data
);

    state_t           state_reg;
    logic [2:0]       idx_reg;
    logic [3:0]       pass_reg;
    logic             busy_reg, done_reg;
    logic             pass_pulse_reg, match_reg, mismatch_reg;
    logic [CNT_W-1:0] match_cnt_reg, err_cnt_reg;
    logic [WIDTH-1:0] rom_data;

    hardreg_pattern_rom #(.WIDTH(WIDTH)) u_rom (
        .idx  (idx_reg),
        .data (rom_data)
    );

    assign exp_data = (state_reg == CHECK) ? rom_data : '0;

    // A strobe only counts in CHECK, and a coincident start discards it.
    logic do_cmp, hit, last_idx, last_pass;
    assign do_cmp    = (state_reg == CHECK) && sample_en && !start;
    assign hit       = (q_in == exp_data);
    assign last_idx  = (idx_reg == 3'(SEQ_LEN - 1));
    assign last_pass = (pass_reg == 4'(PASSES - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            pass_reg       <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            pass_pulse_reg <= 1'b0;
            match_reg      <= 1'b0;
            mismatch_reg   <= 1'b0;
            match_cnt_reg  <= '0;
            err_cnt_reg    <= '0;
        end else begin
            pass_pulse_reg <= 1'b0;
            match_reg      <= 1'b0;
            mismatch_reg   <= 1'b0;
            if (start) begin
                state_reg     <= CHECK;
                busy_reg      <= 1'b1;
                done_reg      <= 1'b0;
                idx_reg       <= '0;
                pass_reg      <= '0;
                match_cnt_reg <= '0;
                err_cnt_reg   <= '0;
            end else if (do_cmp) begin
                match_reg    <= hit;
                mismatch_reg <= !hit;
                if (hit && (match_cnt_reg != '1))
                    match_cnt_reg <= match_cnt_reg + 1'b1;
                if (!hit && (err_cnt_reg != '1))
                    err_cnt_reg <= err_cnt_reg + 1'b1;
                if (last_idx) begin
                    idx_reg        <= '0;
                    pass_pulse_reg <= 1'b1;
                    if (last_pass) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        pass_reg  <= '0;
                    end else begin
                        pass_reg <= pass_reg + 4'd1;
                    end
                end else begin
                    idx_reg <= idx_reg + 3'd1;
                end
            end
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign pass_pulse = pass_pulse_reg;
    assign match      = match_reg;
    assign mismatch   = mismatch_reg;
    assign match_cnt  = match_cnt_reg;
    assign err_cnt    = err_cnt_reg;

`ifdef HARDREG_FIRST_ERR_EN
    logic             err_seen_reg;
    logic [2:0]       first_err_idx_reg;
    logic [WIDTH-1:0] first_err_data_reg;

    // Sticky: only the first mismatch after start/clr is recorded.
    always_ff @(posedge clk) begin
        if (clr || start) begin
            err_seen_reg       <= 1'b0;
            first_err_idx_reg  <= '0;
            first_err_data_reg <= '0;
        end else if (do_cmp && !hit && !err_seen_reg) begin
            err_seen_reg       <= 1'b1;
            first_err_idx_reg  <= idx_reg;
            first_err_data_reg <= q_in;
        end
    end

    assign first_err_idx  = first_err_idx_reg;
    assign first_err_data = first_err_data_reg;
`else
    assign first_err_idx  = 3'd0;
    assign first_err_data = '0;
`endif

endmodule

// File: tb/tb_hardreg_seq_checker.sv
// tb_hardreg_seq_checker -- directed table-driven bench for hardreg_seq_checker.
// A second instance with CNT_W = 2 shares the stimulus to exercise saturation.
module tb_hardreg_seq_checker;

`ifdef HARDREG_FIRST_ERR_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif
    localparam int FE2 = FE ? 2 : 0;
    localparam int FE3 = FE ? 3 : 0;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0;
    logic       sample_en = 1'b0;
    logic [3:0] q_in = 4'd0;

    logic       busy, done, pass_pulse, match, mismatch;
    logic [3:0] exp_data, first_err_data;
    logic [7:0] match_cnt, err_cnt;
    logic [2:0] first_err_idx;

    logic       s_busy, s_done, s_pass_pulse, s_match, s_mismatch;
    logic [3:0] s_exp_data, s_first_err_data;
    logic [1:0] s_match_cnt, s_err_cnt;
    logic [2:0] s_first_err_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hardreg_seq_checker #(.WIDTH(4), .PASSES(2), .CNT_W(8)) dut (
        .clk(clk), .clr(clr), .start(start), .sample_en(sample_en), .q_in(q_in),
        .busy(busy), .done(done), .pass_pulse(pass_pulse), .match(match),
        .mismatch(mismatch), .exp_data(exp_data), .match_cnt(match_cnt),
        .err_cnt(err_cnt), .first_err_idx(first_err_idx),
        .first_err_data(first_err_data)
    );

    hardreg_seq_checker #(.WIDTH(4), .PASSES(2), .CNT_W(2)) dut_sat (
        .clk(clk), .clr(clr), .start(start), .sample_en(sample_en), .q_in(q_in),
        .busy(s_busy), .done(s_done), .pass_pulse(s_pass_pulse), .match(s_match),
        .mismatch(s_mismatch), .exp_data(s_exp_data), .match_cnt(s_match_cnt),
        .err_cnt(s_err_cnt), .first_err_idx(s_first_err_idx),
        .first_err_data(s_first_err_data)
    );

    typedef struct {
        bit         clr;
        bit         start;
        bit         se;
        logic [3:0] q;
        bit         m;
        bit         mm;
        bit         pp;
        bit         busy;
        bit         done;
        int         mc;
        int         ec;
        logic [3:0] ex;
        int         fei;
        int         fed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit c, bit s, bit e, logic [3:0] q,
                                bit m, bit mm, bit pp, bit b, bit d,
                                int mc, int ec, logic [3:0] ex, int fei, int fed);
        vec_t v;
        v.clr = c; v.start = s; v.se = e; v.q = q;
        v.m = m; v.mm = mm; v.pp = pp; v.busy = b; v.done = d;
        v.mc = mc; v.ec = ec; v.ex = ex; v.fei = fei; v.fed = fed;
        return v;
    endfunction

    function automatic int sat3(int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic drive(input bit c, input bit s, input bit e, input logic [3:0] q);
        clr = c; start = s; sample_en = e; q_in = q;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // clean run: two passes, then DONE
        tbl.push_back(mk(1,0,0,0, 0,0,0,0,0,  0,0, 0, 0,0));
        tbl.push_back(mk(0,1,0,0, 0,0,0,1,0,  0,0, 0, 0,0));
        tbl.push_back(mk(0,0,1,0, 1,0,0,1,0,  1,0, 1, 0,0));
        tbl.push_back(mk(0,0,1,1, 1,0,0,1,0,  2,0, 2, 0,0));
        tbl.push_back(mk(0,0,1,2, 1,0,0,1,0,  3,0, 4, 0,0));
        tbl.push_back(mk(0,0,1,4, 1,0,0,1,0,  4,0, 5, 0,0));
        tbl.push_back(mk(0,0,1,5, 1,0,1,1,0,  5,0, 0, 0,0));
        tbl.push_back(mk(0,0,1,0, 1,0,0,1,0,  6,0, 1, 0,0));
        tbl.push_back(mk(0,0,1,1, 1,0,0,1,0,  7,0, 2, 0,0));
        tbl.push_back(mk(0,0,1,2, 1,0,0,1,0,  8,0, 4, 0,0));
        tbl.push_back(mk(0,0,1,4, 1,0,0,1,0,  9,0, 5, 0,0));
        tbl.push_back(mk(0,0,1,5, 1,0,1,0,1, 10,0, 0, 0,0));
        // sample in DONE ignored, pulses drop
        tbl.push_back(mk(0,0,1,0, 0,0,0,0,1, 10,0, 0, 0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,1, 10,0, 0, 0,0));
        // restart from DONE, error at index 2, later mismatch keeps capture
        tbl.push_back(mk(0,1,0,0, 0,0,0,1,0,  0,0, 0, 0,0));
        tbl.push_back(mk(0,0,1,0, 1,0,0,1,0,  1,0, 1, 0,0));
        tbl.push_back(mk(0,0,1,1, 1,0,0,1,0,  2,0, 2, 0,0));
        tbl.push_back(mk(0,0,1,3, 0,1,0,1,0,  2,1, 4, FE2,FE3));
        tbl.push_back(mk(0,0,1,4, 1,0,0,1,0,  3,1, 5, FE2,FE3));
        tbl.push_back(mk(0,0,1,5, 1,0,1,1,0,  4,1, 0, FE2,FE3));
        tbl.push_back(mk(0,0,1,7, 0,1,0,1,0,  4,2, 1, FE2,FE3));
        tbl.push_back(mk(0,0,1,1, 1,0,0,1,0,  5,2, 2, FE2,FE3));
        // clr, then ignore in IDLE, then start colliding with sample_en
        tbl.push_back(mk(1,0,0,0, 0,0,0,0,0,  0,0, 0, 0,0));
        tbl.push_back(mk(0,0,1,0, 0,0,0,0,0,  0,0, 0, 0,0));
        tbl.push_back(mk(0,1,0,0, 0,0,0,1,0,  0,0, 0, 0,0));
        tbl.push_back(mk(0,0,1,0, 1,0,0,1,0,  1,0, 1, 0,0));
        tbl.push_back(mk(0,0,1,1, 1,0,0,1,0,  2,0, 2, 0,0));
        tbl.push_back(mk(0,0,1,2, 1,0,0,1,0,  3,0, 4, 0,0));
        tbl.push_back(mk(0,1,1,4, 0,0,0,1,0,  0,0, 0, 0,0));
        tbl.push_back(mk(0,0,1,0, 1,0,0,1,0,  1,0, 1, 0,0));
        // clr beats start and sample_en
        tbl.push_back(mk(1,1,1,1, 0,0,0,0,0,  0,0, 0, 0,0));
        // clr after 7 samples abandons the run
        tbl.push_back(mk(0,1,0,0, 0,0,0,1,0,  0,0, 0, 0,0));
        tbl.push_back(mk(0,0,1,0, 1,0,0,1,0,  1,0, 1, 0,0));
        tbl.push_back(mk(0,0,1,1, 1,0,0,1,0,  2,0, 2, 0,0));
        tbl.push_back(mk(0,0,1,2, 1,0,0,1,0,  3,0, 4, 0,0));
        tbl.push_back(mk(0,0,1,4, 1,0,0,1,0,  4,0, 5, 0,0));
        tbl.push_back(mk(0,0,1,5, 1,0,1,1,0,  5,0, 0, 0,0));
        tbl.push_back(mk(0,0,1,0, 1,0,0,1,0,  6,0, 1, 0,0));
        tbl.push_back(mk(0,0,1,1, 1,0,0,1,0,  7,0, 2, 0,0));
        tbl.push_back(mk(1,0,1,2, 0,0,0,0,0,  0,0, 0, 0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,0,  0,0, 0, 0,0));
        tbl.push_back(mk(0,0,1,2, 0,0,0,0,0,  0,0, 0, 0,0));

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].start, tbl[i].se, tbl[i].q);
            $display("vec %0d: clr=%0b start=%0b se=%0b q=%0d -> m=%0b mm=%0b pp=%0b busy=%0b done=%0b mc=%0d ec=%0d exp=%0d fe=%0d/%0d",
                     i, tbl[i].clr, tbl[i].start, tbl[i].se, tbl[i].q, match, mismatch,
                     pass_pulse, busy, done, match_cnt, err_cnt, exp_data,
                     first_err_idx, first_err_data);
            chk($sformatf("v%0d match", i),      int'(match),          int'(tbl[i].m));
            chk($sformatf("v%0d mismatch", i),   int'(mismatch),       int'(tbl[i].mm));
            chk($sformatf("v%0d pass_pulse", i), int'(pass_pulse),     int'(tbl[i].pp));
            chk($sformatf("v%0d busy", i),       int'(busy),           int'(tbl[i].busy));
            chk($sformatf("v%0d done", i),       int'(done),           int'(tbl[i].done));
            chk($sformatf("v%0d match_cnt", i),  int'(match_cnt),      tbl[i].mc);
            chk($sformatf("v%0d err_cnt", i),    int'(err_cnt),        tbl[i].ec);
            chk($sformatf("v%0d exp_data", i),   int'(exp_data),       int'(tbl[i].ex));
            chk($sformatf("v%0d fe_idx", i),     int'(first_err_idx),  tbl[i].fei);
            chk($sformatf("v%0d fe_data", i),    int'(first_err_data), tbl[i].fed);
            chk($sformatf("v%0d sat_mc", i),     int'(s_match_cnt),    sat3(tbl[i].mc));
            chk($sformatf("v%0d sat_ec", i),     int'(s_err_cnt),      sat3(tbl[i].ec));
        end

        // saturation: six mismatches, narrow counter holds at 3
        drive(0, 1, 0, 0);
        $display("sat start: busy=%0b err_cnt=%0d", s_busy, s_err_cnt);
        chk("sat start busy", int'(s_busy), 1);
        for (int k = 1; k <= 6; k++) begin
            drive(0, 0, 1, 4'hF);
            $display("sat %0d: mm=%0b pp=%0b err_cnt=%0d sat_err_cnt=%0d",
                     k, s_mismatch, s_pass_pulse, err_cnt, s_err_cnt);
            chk($sformatf("sat%0d mismatch", k),   int'(s_mismatch),   1);
            chk($sformatf("sat%0d pass_pulse", k), int'(s_pass_pulse), (k == 5) ? 1 : 0);
            chk($sformatf("sat%0d wide_ec", k),    int'(err_cnt),      k);
            chk($sformatf("sat%0d sat_ec", k),     int'(s_err_cnt),    sat3(k));
            chk($sformatf("sat%0d sat_mc", k),     int'(s_match_cnt),  0);
            chk($sformatf("sat%0d fe_idx", k),     int'(first_err_idx), 0);
            chk($sformatf("sat%0d fe_data", k),    int'(first_err_data), FE ? 15 : 0);
        end
        drive(0, 0, 0, 0);
        $display("sat hold: sat_err_cnt=%0d", s_err_cnt);
        chk("sat hold ec", int'(s_err_cnt), 3);
        chk("sat hold mm", int'(s_mismatch), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hardreg_seq_checker.md
HARDREG_SEQ_CHECKER -- requirements
Module: hardreg_seq_checker

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data width checked.
REQ-002 Parameter PASSES, default 2, SHALL set the number of full pattern passes per run (legal range 1..15).
REQ-003 Parameter CNT_W, default 8, SHALL set the width of the match and error counters.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 clr  input  1  SHALL be the synchronous, active-high reset.
REQ-006 start  input  1  SHALL be a one-cycle pulse that begins or restarts a run.
REQ-007 sample_en  input  1  SHALL be a strobe that marks q_in valid for one comparison.
REQ-008 q_in  input  WIDTH  SHALL be the observed register output (hardreg q).
REQ-009 busy  output  1  SHALL be high while in CHECK.
REQ-010 done  output  1  SHALL be high while in DONE.
REQ-011 pass_pulse  output  1  SHALL be a one-cycle pulse on each completed pass.
REQ-012 match  output  1  SHALL be a one-cycle pulse for a compare that matched.
REQ-013 mismatch  output  1  SHALL be a one-cycle pulse for a compare that failed.
REQ-014 exp_data  output  WIDTH  SHALL show the value expected at the next sample.
REQ-015 match_cnt, err_cnt  output  CNT_W  SHALL hold the cumulative compare results for the run.
REQ-016 first_err_idx  output  3  SHALL hold the sequence index of the first mismatch in the run.
REQ-017 first_err_data  output  WIDTH  SHALL hold the q_in value of the first mismatch in the run.

Function
REQ-018 The expected sequence SHALL be 0000, 0001, 0010, 0100, 0101 at indices 0..4, zero-extended to WIDTH, and SHALL repeat for PASSES passes.
REQ-019 The FSM SHALL have states IDLE, CHECK and DONE.
- IDLE->CHECK on start.
- CHECK->DONE on the last compare of pass PASSES.
- DONE->CHECK on start.
- Any state->IDLE on clr.
REQ-020 In CHECK, each sample_en SHALL compare q_in with exp_data; the compare result SHALL appear on match/mismatch one cycle later (registered), and idx SHALL advance.
REQ-021 idx SHALL wrap from 4 to 0; pass_pulse SHALL assert in the same cycle as the result for index 4.
REQ-022 sample_en in IDLE or DONE SHALL be ignored: no compare, no counter change.
REQ-023 start SHALL clear idx, the pass count, both counters, the first-error registers and the first-error-seen flag, and SHALL enter CHECK.
REQ-024 start in CHECK SHALL restart the run. If start and sample_en coincide, start wins and the sample is discarded.
REQ-025 match_cnt and err_cnt SHALL saturate at all-ones and never wrap.
REQ-026 exp_data SHALL be combinational from idx and SHALL show 0000 outside CHECK.

Reset
REQ-027 On clr, the following SHALL all go to 0:
- state IDLE, idx, pass count;
- busy, done, pass_pulse, match, mismatch;
- match_cnt, err_cnt, first_err_idx, first_err_data.
REQ-028 clr SHALL override start and sample_en in the same cycle. clr mid-run SHALL abandon the run without emitting pass_pulse.

Configuration
REQ-029 Macro HARDREG_FIRST_ERR_EN SHALL control first-error capture.
- Defined: first_err_idx and first_err_data SHALL latch on the first mismatch of a run and stay sticky until start or clr.
- Undefined: both outputs SHALL be tied to 0 and no capture flops SHALL exist.

Structure
REQ-030 Package hardreg_pkg SHALL hold:
- SEQ_LEN = 5;
- the five pattern constants;
- the state encoding IDLE = 2'd0, CHECK = 2'd1, DONE = 2'd2.
REQ-031 Sub-module hardreg_pattern_rom SHALL map a 3-bit idx to the WIDTH-bit expected value, combinationally. Indices 5..7 SHALL return 0.

Verification
REQ-032 Clean run: clr, start, then 10 sample_en with q_in = 0,1,2,4,5,0,1,2,4,5 -> match_cnt = 10, err_cnt = 0, two pass_pulse, then done = 1 and busy = 0.
REQ-033 Error capture (macro defined): q_in = 0,1,3,4,5 on pass 1 -> err_cnt = 1, first_err_idx = 2, first_err_data = 0011. A later mismatch SHALL NOT overwrite the capture.
REQ-034 Ignore and restart: sample_en in IDLE -> counters stay 0. start asserted with sample_en after 3 samples -> idx = 0, counters = 0, and that sample is not counted.
REQ-035 Reset mid-run: clr after 7 samples -> all outputs 0, state IDLE, no pass_pulse in that cycle or after.
REQ-036 Saturation: CNT_W = 2, 6 mismatches -> err_cnt holds at 3.
REQ-037 Macro undefined: same stimulus as REQ-033 -> first_err_idx = 0 and first_err_data = 0 throughout.
